// File: rtl/exu_ctrl_pkg.sv
// rvseed execute-stage shared definitions:
// field widths, FSM encodings and the latched control bundle.
package exu_ctrl_pkg;

  localparam int BRAN_WIDTH     = 3;
  localparam int JUMP_WIDTH     = 2;
  localparam int REG_ADDR_WIDTH = 5;

  typedef logic [1:0] exu_state_t;

  localparam exu_state_t IDLE = 2'd0;
  localparam exu_state_t EXEC = 2'd1;
  localparam exu_state_t MEM  = 2'd2;
  localparam exu_state_t DONE = 2'd3;

  typedef struct packed {
    logic [BRAN_WIDTH-1:0]     branch;
    logic [JUMP_WIDTH-1:0]     jump;
    logic                      reg_wen;
    logic [REG_ADDR_WIDTH-1:0] reg_waddr;
    logic                      mem_op;
  } exu_ctl_t;

endpackage

// File: rtl/exu_fwd_unit.sv
// Last-write tracker and source comparators for
// operand forwarding into the execute stage.
module exu_fwd_unit
  import exu_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] wr_addr,
  input  logic                      flush,
  input  logic                      qual,
  input  logic [REG_ADDR_WIDTH-1:0] raddr1,
  input  logic [REG_ADDR_WIDTH-1:0] raddr2,
  output logic                      fwd_sel1,
  output logic                      fwd_sel2
);

  logic                      lw_valid;
  logic [REG_ADDR_WIDTH-1:0] lw_addr;
  logic                      hit_ok;

  // A redirected instruction never becomes a forwarding source.
  always_ff @(posedge clk) begin
    if (rst) begin
      lw_valid <= 1'b0;
      lw_addr  <= '0;
    end else if (flush) begin
      lw_valid <= 1'b0;
    end else if (wr_en) begin
      lw_valid <= 1'b1;
      lw_addr  <= wr_addr;
    end
  end

  assign hit_ok   = qual & lw_valid & (lw_addr != '0);
  assign fwd_sel1 = hit_ok & (raddr1 == lw_addr);
  assign fwd_sel2 = hit_ok & (raddr2 == lw_addr);

endmodule

// File: rtl/exu_ctrl.sv
// rvseed execute-stage sequencer: IDU handshake, memory
// wait with timeout, redirect, writeback strobe, retire count.
module exu_ctrl
  import exu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      idu_done_en,
  output logic                      exu_ready,
  input  logic [BRAN_WIDTH-1:0]     idu_inst_branch,
  input  logic [JUMP_WIDTH-1:0]     idu_inst_jump,
  input  logic                      idu_inst_reg_wen,
  input  logic [REG_ADDR_WIDTH-1:0] idu_inst_reg_waddr,
  input  logic [REG_ADDR_WIDTH-1:0] idu_inst_reg1_raddr,
  input  logic [REG_ADDR_WIDTH-1:0] idu_inst_reg2_raddr,
  input  logic                      idu_inst_mem_wen,
  input  logic                      idu_inst_mem_ren,
  input  logic                      alu_bran_taken,
  output logic                      alu_en,
  output logic                      lsu_req,
  input  logic                      lsu_ack,
  output logic                      redirect,
  output logic                      reg_wen,
  output logic [REG_ADDR_WIDTH-1:0] reg_waddr,
  output logic                      fwd_sel1,
  output logic                      fwd_sel2,
  output logic                      exu_done_en,
  output logic                      mem_err,
  output logic [31:0]               retired_cnt
);

  exu_state_t      state;
  exu_state_t      state_nx;
  exu_ctl_t        ctl;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic            to_last;
  logic            accept;
  logic            wr_commit;
  logic [31:0]     ret_q;

  assign exu_ready = enable & ~rst & ((state == IDLE) | (state == DONE));
  assign accept    = exu_ready & idu_done_en;
  assign alu_en    = accept;
  assign to_last   = (to_cnt == TO_W'(MEM_TIMEOUT - 1));
  assign reg_waddr = ctl.reg_waddr;
  assign retired_cnt = ret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (enable) begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (idu_done_en) state_nx = EXEC;
      EXEC:    state_nx = ctl.mem_op ? MEM : DONE;
      MEM:     if (lsu_ack | to_last) state_nx = DONE;
      DONE:    state_nx = idu_done_en ? EXEC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    redirect    = 1'b0;
    lsu_req     = 1'b0;
    exu_done_en = 1'b0;
    reg_wen     = 1'b0;
    if (enable) begin
      unique case (state)
        EXEC: redirect = (|ctl.jump) |
                         ((|ctl.branch) & alu_bran_taken);
        MEM:  lsu_req = 1'b1;
        DONE: begin
          exu_done_en = 1'b1;
          reg_wen     = ctl.reg_wen & (ctl.reg_waddr != '0) & ~to_hit;
        end
        default: ;
      endcase
    end
  end

  // Ack wins over the timeout when both land in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl     <= '0;
      to_cnt  <= '0;
      to_hit  <= 1'b0;
      mem_err <= 1'b0;
      ret_q   <= '0;
    end else if (enable) begin
      if (accept) begin
        ctl <= '{branch:    idu_inst_branch,
                 jump:      idu_inst_jump,
                 reg_wen:   idu_inst_reg_wen,
                 reg_waddr: idu_inst_reg_waddr,
                 mem_op:    idu_inst_mem_ren | idu_inst_mem_wen};
        to_hit <= 1'b0;
      end
      if (state == EXEC) to_cnt <= '0;
      if ((state == MEM) && !lsu_ack) begin
        if (to_last) begin
          to_hit  <= 1'b1;
          mem_err <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
      if (state == DONE) ret_q <= ret_q + 32'd1;
    end
  end

  // The result written in DONE is forwardable during DONE itself.
  assign wr_commit = enable & ctl.reg_wen & (ctl.reg_waddr != '0) &
                     (((state == EXEC) & ~ctl.mem_op) |
                      ((state == MEM) & lsu_ack));

  exu_fwd_unit u_fwd (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_commit),
    .wr_addr  (ctl.reg_waddr),
    .flush    (redirect),
    .qual     (alu_en),
    .raddr1   (idu_inst_reg1_raddr),
    .raddr2   (idu_inst_reg2_raddr),
    .fwd_sel1 (fwd_sel1),
    .fwd_sel2 (fwd_sel2)
  );

endmodule

// File: tb/tb_exu_ctrl.sv
// Self-checking bench for exu_ctrl: directed scenarios plus
// randomized instruction streams against a transaction model.
module tb_exu_ctrl;
  import exu_ctrl_pkg::*;

  localparam int TO = 4;

  typedef struct packed {
    logic [BRAN_WIDTH-1:0]     br;
    logic [JUMP_WIDTH-1:0]     jp;
    logic                      wen;
    logic [REG_ADDR_WIDTH-1:0] wa;
    logic [REG_ADDR_WIDTH-1:0] r1;
    logic [REG_ADDR_WIDTH-1:0] r2;
    logic                      mw;
    logic                      mr;
  } inst_t;

  logic clk = 1'b0;
  logic rst, enable, idu_done_en, exu_ready;
  logic [BRAN_WIDTH-1:0] idu_inst_branch;
  logic [JUMP_WIDTH-1:0] idu_inst_jump;
  logic idu_inst_reg_wen;
  logic [REG_ADDR_WIDTH-1:0] idu_inst_reg_waddr;
  logic [REG_ADDR_WIDTH-1:0] idu_inst_reg1_raddr;
  logic [REG_ADDR_WIDTH-1:0] idu_inst_reg2_raddr;
  logic idu_inst_mem_wen, idu_inst_mem_ren;
  logic alu_bran_taken, alu_en, lsu_req, lsu_ack;
  logic redirect, reg_wen;
  logic [REG_ADDR_WIDTH-1:0] reg_waddr;
  logic fwd_sel1, fwd_sel2, exu_done_en, mem_err;
  logic [31:0] retired_cnt;

  int n_chk = 0;
  int n_fail = 0;

  bit lw_valid;
  logic [REG_ADDR_WIDTH-1:0] lw_addr;
  logic [31:0] model_cnt;
  bit model_err;

  always #5 clk = ~clk;

  exu_ctrl #(.MEM_TIMEOUT(TO), .TO_W(3)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .enable              (enable),
    .idu_done_en         (idu_done_en),
    .exu_ready           (exu_ready),
    .idu_inst_branch     (idu_inst_branch),
    .idu_inst_jump       (idu_inst_jump),
    .idu_inst_reg_wen    (idu_inst_reg_wen),
    .idu_inst_reg_waddr  (idu_inst_reg_waddr),
    .idu_inst_reg1_raddr (idu_inst_reg1_raddr),
    .idu_inst_reg2_raddr (idu_inst_reg2_raddr),
    .idu_inst_mem_wen    (idu_inst_mem_wen),
    .idu_inst_mem_ren    (idu_inst_mem_ren),
    .alu_bran_taken      (alu_bran_taken),
    .alu_en              (alu_en),
    .lsu_req             (lsu_req),
    .lsu_ack             (lsu_ack),
    .redirect            (redirect),
    .reg_wen             (reg_wen),
    .reg_waddr           (reg_waddr),
    .fwd_sel1            (fwd_sel1),
    .fwd_sel2            (fwd_sel2),
    .exu_done_en         (exu_done_en),
    .mem_err             (mem_err),
    .retired_cnt         (retired_cnt)
  );

  function automatic inst_t mk(
    input logic [BRAN_WIDTH-1:0] br, input logic [JUMP_WIDTH-1:0] jp,
    input logic wen, input logic [REG_ADDR_WIDTH-1:0] wa,
    input logic [REG_ADDR_WIDTH-1:0] r1, input logic [REG_ADDR_WIDTH-1:0] r2,
    input logic mw, input logic mr);
    inst_t t;
    t.br = br; t.jp = jp; t.wen = wen; t.wa = wa;
    t.r1 = r1; t.r2 = r2; t.mw = mw; t.mr = mr;
    return t;
  endfunction

  task automatic drive(input inst_t in);
    idu_inst_branch     = in.br;
    idu_inst_jump       = in.jp;
    idu_inst_reg_wen    = in.wen;
    idu_inst_reg_waddr  = in.wa;
    idu_inst_reg1_raddr = in.r1;
    idu_inst_reg2_raddr = in.r2;
    idu_inst_mem_wen    = in.mw;
    idu_inst_mem_ren    = in.mr;
  endtask

  task automatic model_reset();
    lw_valid  = 1'b0;
    lw_addr   = '0;
    model_cnt = '0;
    model_err = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    idu_done_en = 1'b0;
    lsu_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
  endtask

  // One instruction from acceptance through DONE; starts and
  // ends just after a falling edge of a ready cycle.
  task automatic run_inst(input inst_t in, input bit taken,
                          input int ack_at, input bit b2b,
                          output logic f1, output logic f2);
    bit redir, wr, to;
    logic e1, e2;
    inst_t noise;
    drive(in);
    idu_done_en = 1'b1;
    #1;
    e1 = lw_valid && (in.r1 == lw_addr) && (lw_addr != 0);
    e2 = lw_valid && (in.r2 == lw_addr) && (lw_addr != 0);
    f1 = fwd_sel1;
    f2 = fwd_sel2;
    n_chk++; if (exu_ready !== 1'b1) begin n_fail++; $display("FAIL acc_ready got=%b exp=1", exu_ready); end
    n_chk++; if (alu_en !== 1'b1) begin n_fail++; $display("FAIL acc_alu_en got=%b exp=1", alu_en); end
    n_chk++; if (fwd_sel1 !== e1) begin n_fail++; $display("FAIL fwd_sel1 got=%b exp=%b", fwd_sel1, e1); end
    n_chk++; if (fwd_sel2 !== e2) begin n_fail++; $display("FAIL fwd_sel2 got=%b exp=%b", fwd_sel2, e2); end
    @(posedge clk); @(negedge clk);
    idu_done_en = 1'b0;
    noise = inst_t'($bits(inst_t)'($urandom));
    drive(noise);
    alu_bran_taken = taken;
    lsu_ack = 1'($urandom_range(0, 1));
    #1;
    redir = (in.jp != 0) || ((in.br != 0) && taken);
    n_chk++; if (redirect !== redir) begin n_fail++; $display("FAIL exec_redirect got=%b exp=%b", redirect, redir); end
    n_chk++; if (exu_ready !== 1'b0) begin n_fail++; $display("FAIL exec_ready got=%b exp=0", exu_ready); end
    n_chk++; if ({exu_done_en, reg_wen, lsu_req, fwd_sel1} !== 4'b0) begin n_fail++; $display("FAIL exec_quiet got=%b exp=0000", {exu_done_en, reg_wen, lsu_req, fwd_sel1}); end
    n_chk++; if (retired_cnt !== model_cnt) begin n_fail++; $display("FAIL exec_cnt got=%h exp=%h", retired_cnt, model_cnt); end
    if (redir) lw_valid = 1'b0;
    to = 1'b0;
    if (in.mw || in.mr) begin
      for (int c = 1; c <= TO; c++) begin
        @(posedge clk); @(negedge clk);
        lsu_ack = (c == ack_at);
        idu_done_en = 1'($urandom_range(0, 1));
        #1;
        n_chk++; if (lsu_req !== 1'b1) begin n_fail++; $display("FAIL mem_req c=%0d got=%b exp=1", c, lsu_req); end
        n_chk++; if ({exu_ready, alu_en, exu_done_en} !== 3'b0) begin n_fail++; $display("FAIL mem_quiet c=%0d got=%b exp=000", c, {exu_ready, alu_en, exu_done_en}); end
        if (c == ack_at) break;
        to = (c == TO);
      end
    end
    @(posedge clk); @(negedge clk);
    lsu_ack = 1'b0;
    idu_done_en = 1'b0;
    #1;
    wr = in.wen && (in.wa != 0) && !to;
    if (to) model_err = 1'b1;
    n_chk++; if (exu_done_en !== 1'b1) begin n_fail++; $display("FAIL done_pulse got=%b exp=1", exu_done_en); end
    n_chk++; if (reg_wen !== wr) begin n_fail++; $display("FAIL done_reg_wen got=%b exp=%b", reg_wen, wr); end
    n_chk++; if ({lsu_req, redirect} !== 2'b0) begin n_fail++; $display("FAIL done_quiet got=%b exp=00", {lsu_req, redirect}); end
    n_chk++; if (exu_ready !== 1'b1) begin n_fail++; $display("FAIL done_ready got=%b exp=1", exu_ready); end
    n_chk++; if (retired_cnt !== model_cnt) begin n_fail++; $display("FAIL done_cnt got=%h exp=%h", retired_cnt, model_cnt); end
    n_chk++; if (mem_err !== model_err) begin n_fail++; $display("FAIL done_mem_err got=%b exp=%b", mem_err, model_err); end
    if (wr) begin
      n_chk++; if (reg_waddr !== in.wa) begin n_fail++; $display("FAIL done_waddr got=%0d exp=%0d", reg_waddr, in.wa); end
    end
    if (wr && !redir) begin
      lw_valid = 1'b1;
      lw_addr  = in.wa;
    end
    model_cnt = model_cnt + 32'd1;
    if (!b2b) begin
      @(posedge clk); @(negedge clk);
      lsu_ack = 1'($urandom_range(0, 1));
      #1;
      n_chk++; if (exu_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready got=%b exp=1", exu_ready); end
      n_chk++; if ({exu_done_en, reg_wen, lsu_req, alu_en} !== 4'b0) begin n_fail++; $display("FAIL idle_quiet got=%b exp=0000", {exu_done_en, reg_wen, lsu_req, alu_en}); end
      n_chk++; if (retired_cnt !== model_cnt) begin n_fail++; $display("FAIL idle_cnt got=%h exp=%h", retired_cnt, model_cnt); end
      lsu_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; idu_done_en = 1'b0;
    drive('0);
    alu_bran_taken = 1'b0; lsu_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_chk++; if (exu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", exu_ready); end
    rst = 1'b0;
    #1;
    model_reset();
    n_chk++; if (exu_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready got=%b exp=1", exu_ready); end
    n_chk++; if (retired_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_cnt got=%h exp=0", retired_cnt); end
    n_chk++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL rst_mem_err got=%b exp=0", mem_err); end
    n_chk++; if ({alu_en, lsu_req, redirect, reg_wen, fwd_sel1, fwd_sel2, exu_done_en} !== 7'b0) begin n_fail++; $display("FAIL rst_outs got=%b exp=0", {alu_en, lsu_req, redirect, reg_wen, fwd_sel1, fwd_sel2, exu_done_en}); end
    n_chk++; if (reg_waddr !== '0) begin n_fail++; $display("FAIL rst_waddr got=%0d exp=0", reg_waddr); end
  endtask

  task automatic test_add();
    logic f1, f2;
    run_inst(mk(3'd0, 2'd0, 1'b1, 5'd5, 5'd1, 5'd2, 1'b0, 1'b0), 1'b0, 0, 1'b0, f1, f2);
    n_chk++; if (retired_cnt !== 32'd1) begin n_fail++; $display("FAIL add_cnt got=%h exp=1", retired_cnt); end
  endtask

  task automatic test_back_to_back();
    logic f1, f2;
    run_inst(mk(3'd0, 2'd0, 1'b1, 5'd5, 5'd3, 5'd4, 1'b0, 1'b0), 1'b0, 0, 1'b1, f1, f2);
    run_inst(mk(3'd0, 2'd0, 1'b1, 5'd6, 5'd5, 5'd7, 1'b0, 1'b0), 1'b0, 0, 1'b0, f1, f2);
    n_chk++; if (f1 !== 1'b1) begin n_fail++; $display("FAIL b2b_fwd1 got=%b exp=1", f1); end
    n_chk++; if (f2 !== 1'b0) begin n_fail++; $display("FAIL b2b_fwd2 got=%b exp=0", f2); end
  endtask

  task automatic test_jal();
    logic f1, f2;
    run_inst(mk(3'd0, 2'd1, 1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0), 1'b0, 0, 1'b1, f1, f2);
    run_inst(mk(3'd0, 2'd0, 1'b1, 5'd9, 5'd1, 5'd1, 1'b0, 1'b0), 1'b0, 0, 1'b0, f1, f2);
    n_chk++; if ({f1, f2} !== 2'b00) begin n_fail++; $display("FAIL jal_fwd got=%b exp=00", {f1, f2}); end
  endtask

  task automatic test_load();
    logic f1, f2;
    run_inst(mk(3'd0, 2'd0, 1'b1, 5'd3, 5'd2, 5'd0, 1'b0, 1'b1), 1'b0, 3, 1'b0, f1, f2);
    n_chk++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL load_mem_err got=%b exp=0", mem_err); end
  endtask

  task automatic test_store_timeout();
    logic f1, f2;
    run_inst(mk(3'd0, 2'd0, 1'b0, 5'd0, 5'd2, 5'd3, 1'b1, 1'b0), 1'b0, 0, 1'b0, f1, f2);
    n_chk++; if (mem_err !== 1'b1) begin n_fail++; $display("FAIL sw_timeout_err got=%b exp=1", mem_err); end
    run_inst(mk(3'd0, 2'd0, 1'b1, 5'd8, 5'd1, 5'd1, 1'b0, 1'b0), 1'b0, 0, 1'b0, f1, f2);
    n_chk++; if (mem_err !== 1'b1) begin n_fail++; $display("FAIL mem_err_sticky got=%b exp=1", mem_err); end
  endtask

  task automatic test_reset_mid_mem();
    drive(mk(3'd0, 2'd0, 1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b1));
    idu_done_en = 1'b1;
    @(posedge clk); @(negedge clk);
    idu_done_en = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    n_chk++; if (lsu_req !== 1'b1) begin n_fail++; $display("FAIL mid_mem_req got=%b exp=1", lsu_req); end
    rst = 1'b1;
    #1;
    n_chk++; if (exu_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready got=%b exp=0", exu_ready); end
    @(posedge clk); @(negedge clk); #1;
    n_chk++; if (lsu_req !== 1'b0) begin n_fail++; $display("FAIL mid_rst_req got=%b exp=0", lsu_req); end
    rst = 1'b0;
    #1;
    model_reset();
    n_chk++; if ({exu_ready, mem_err} !== 2'b10) begin n_fail++; $display("FAIL mid_rst_state got=%b exp=10", {exu_ready, mem_err}); end
    n_chk++; if (retired_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_rst_cnt got=%h exp=0", retired_cnt); end
  endtask

  task automatic test_enable_freeze();
    drive(mk(3'd0, 2'd0, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b1));
    idu_done_en = 1'b1;
    @(posedge clk); @(negedge clk);
    idu_done_en = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk); @(negedge clk); #1;
      n_chk++; if (lsu_req !== 1'b1) begin n_fail++; $display("FAIL frz_pre_req c=%0d got=%b exp=1", c, lsu_req); end
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      enable = 1'b0;
      idu_done_en = 1'b1;
      lsu_ack = 1'(i % 2);
      #1;
      n_chk++; if ({lsu_req, exu_ready, alu_en, exu_done_en, redirect, reg_wen} !== 6'b0) begin n_fail++; $display("FAIL frz_quiet i=%0d got=%b exp=0", i, {lsu_req, exu_ready, alu_en, exu_done_en, redirect, reg_wen}); end
      n_chk++; if (retired_cnt !== model_cnt) begin n_fail++; $display("FAIL frz_cnt got=%h exp=%h", retired_cnt, model_cnt); end
    end
    @(posedge clk); @(negedge clk);
    enable = 1'b1; idu_done_en = 1'b0; lsu_ack = 1'b0;
    #1;
    n_chk++; if (lsu_req !== 1'b1) begin n_fail++; $display("FAIL frz_resume_req got=%b exp=1", lsu_req); end
    @(posedge clk); @(negedge clk);
    lsu_ack = 1'b1;
    #1;
    n_chk++; if (lsu_req !== 1'b1) begin n_fail++; $display("FAIL frz_last_req got=%b exp=1", lsu_req); end
    @(posedge clk); @(negedge clk);
    lsu_ack = 1'b0;
    #1;
    n_chk++; if ({exu_done_en, reg_wen, mem_err} !== 3'b110) begin n_fail++; $display("FAIL frz_done got=%b exp=110", {exu_done_en, reg_wen, mem_err}); end
    n_chk++; if (reg_waddr !== 5'd7) begin n_fail++; $display("FAIL frz_waddr got=%0d exp=7", reg_waddr); end
    lw_valid = 1'b1; lw_addr = 5'd7;
    model_cnt = model_cnt + 32'd1;
    @(posedge clk); @(negedge clk); #1;
    n_chk++; if (retired_cnt !== model_cnt) begin n_fail++; $display("FAIL frz_post_cnt got=%h exp=%h", retired_cnt, model_cnt); end
  endtask

  task automatic test_wrap();
    logic f1, f2;
    force dut.ret_q = 32'hFFFF_FFFF;
    @(posedge clk); @(negedge clk);
    release dut.ret_q;
    #1;
    model_cnt = 32'hFFFF_FFFF;
    n_chk++; if (retired_cnt !== model_cnt) begin n_fail++; $display("FAIL wrap_preload got=%h exp=%h", retired_cnt, model_cnt); end
    run_inst(mk(3'd0, 2'd0, 1'b1, 5'd2, 5'd7, 5'd7, 1'b0, 1'b0), 1'b0, 0, 1'b0, f1, f2);
    n_chk++; if (retired_cnt !== 32'd0) begin n_fail++; $display("FAIL wrap_zero got=%h exp=0", retired_cnt); end
  endtask

  task automatic test_random();
    inst_t in;
    logic f1, f2;
    int kind;
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 3));
      in = '0;
      in.wen = 1'($urandom_range(0, 1));
      in.wa  = REG_ADDR_WIDTH'($urandom_range(0, 7));
      in.r1  = REG_ADDR_WIDTH'($urandom_range(0, 7));
      in.r2  = REG_ADDR_WIDTH'($urandom_range(0, 7));
      if (kind == 1) in.br = BRAN_WIDTH'($urandom_range(1, 7));
      if (kind == 2) in.jp = JUMP_WIDTH'($urandom_range(1, 3));
      if (kind == 3) begin
        if ($urandom_range(0, 1) == 1) in.mr = 1'b1;
        else in.mw = 1'b1;
      end
      run_inst(in, 1'($urandom_range(0, 1)), int'($urandom_range(0, TO)),
               (i != 59) && ($urandom_range(0, 1) == 1), f1, f2);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_jal();
    test_load();
    test_store_timeout();
    test_reset_mid_mem();
    test_enable_freeze();
    test_wrap();
    reset_dut();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/exu_ctrl.md
# exu_ctrl

Sequencing controller for the execute stage of the rvseed core. It accepts decoded instructions from the IDU with a valid/ready handshake and steps each one through the shared ALU/MUX_ALU datapath. Loads and stores run as a multi-cycle memory handshake with a timeout. The block resolves branch/jump redirects, generates register-write strobes and operand-forwarding selects, and keeps a retired-instruction counter. It sits between the IDU and the EXU datapath and holds no operand data itself.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum cycles to wait in MEM for lsu_ack before flagging an error.
- TO_W, 8: timeout counter width; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports (clk and rst first):
- clk  in  1  single core clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- enable  in  1  rvseed enable; low freezes all state, counters and the FSM.
- idu_done_en  in  1  IDU instruction valid.
- exu_ready  out  1  EXU can accept an instruction this cycle.
- idu_inst_branch  in  `BRAN_WIDTH  branch type; nonzero means conditional branch.
- idu_inst_jump  in  `JUMP_WIDTH  jump type; nonzero means unconditional jump.
- idu_inst_reg_wen  in  1  instruction writes rd.
- idu_inst_reg_waddr  in  `REG_ADDR_WIDTH  rd address.
- idu_inst_reg1_raddr / idu_inst_reg2_raddr  in  `REG_ADDR_WIDTH  source addresses.
- idu_inst_mem_wen / idu_inst_mem_ren  in  1  store / load.
- alu_bran_taken  in  1  branch condition result from the ALU compare (uses zero), valid in EXEC.
- alu_en  out  1  capture-enable for the EXU operand/opcode registers.
- lsu_req  out  1  memory request; held until ack.
- lsu_ack  in  1  memory completion.
- redirect  out  1  one-cycle PC redirect / IDU flush pulse.
- reg_wen  out  1  one-cycle register-file write strobe.
- reg_waddr  out  `REG_ADDR_WIDTH  write address, stable while reg_wen is high.
- fwd_sel1 / fwd_sel2  out  1  select forwarded result for src1 / src2.
- exu_done_en  out  1  one-cycle retire pulse.
- mem_err  out  1  sticky timeout error; cleared only by rst.
- retired_cnt  out  32  retired instructions; wraps modulo 2^32.

## Operation
FSM states: IDLE, EXEC, MEM, DONE.
- **IDLE**
  - exu_ready=1.
  - idu_done_en & enable: alu_en=1 for that cycle, latch the control fields, go to EXEC.
- **EXEC**
  - exu_ready=0.
  - If jump is nonzero, or branch is nonzero and alu_bran_taken: redirect=1 for this cycle.
  - If mem_ren|mem_wen: go to MEM and clear the timeout counter. Otherwise go to DONE.
- **MEM**
  - lsu_req=1 and the counter increments.
  - lsu_ack: go to DONE.
  - Counter reaches MEM_TIMEOUT without ack: set mem_err, drop lsu_req, go to DONE. No register write occurs in this case.
- **DONE**
  - exu_done_en=1 and retired_cnt increments.
  - reg_wen=1 iff the latched reg_wen is set, the latched waddr ≠ 0, and there was no timeout.
  - exu_ready=1. If idu_done_en is high, accept the next instruction and go straight to EXEC (back-to-back). Otherwise go to IDLE.

Forwarding:
- A last-write register holds {valid, addr}. It is loaded in DONE whenever reg_wen fires, and cleared by rst and by redirect.
- fwd_selN = valid & (idu_inst_regN_raddr == addr) & (addr ≠ 0). It is combinational and qualified only in cycles with alu_en=1.

Other rules:
- enable=0 holds the state, counters and latched fields. All pulse outputs are 0 and exu_ready=0.
- An instruction accepted in the same cycle lsu_ack arrives is not possible, because exu_ready=0 in MEM.

## Timing
- Reset values: FSM=IDLE, exu_ready=1 after reset (0 while rst is high), every other output 0, retired_cnt=0, mem_err=0.
- Latency for a non-memory instruction: accept edge, then EXEC, then DONE. exu_done_en rises 2 cycles after acceptance. Throughput is 1 instruction per 2 cycles.
- Memory instruction: exu_done_en comes 1 cycle after the lsu_ack cycle. With ack in the first MEM cycle, the total latency is 3 cycles.
- redirect is coincident with EXEC. The IDU must drop its fetched instruction.
- lsu_ack outside MEM is ignored. lsu_ack on the exact timeout cycle counts as an ack, with no error.
- rst mid-MEM: lsu_req drops on the next edge and the instruction is lost.
- retired_cnt wraps 0xFFFF_FFFF → 0.

## Structure
- State encodings (2-bit, localparams IDLE/EXEC/MEM/DONE) go in the shared rvseed defines file next to the `BRAN_WIDTH/`JUMP_WIDTH macros.
- Natural sub-module: exu_fwd_unit (last-write register plus comparators).
- The FSM and counters live in the top level.

## Test plan
- ADD x5 accepted at cycle 0 → alu_en@0, exu_done_en and reg_wen with reg_waddr=5 @2, retired_cnt=1.
- Back-to-back: ADD x5 then SUB x6,x5 → second accepted in DONE@2, fwd_sel1=1@2, second done@4.
- JAL x1 → redirect@1, last-write cleared, reg_wen with waddr=1 @2, fwd_sel=0 for the next instruction sourcing x1.
- LW with lsu_ack 3 cycles after entering MEM → lsu_req high for 3 cycles, exu_done_en 1 cycle later.
- SW with no ack, MEM_TIMEOUT=4 → mem_err set after 4 MEM cycles, reg_wen=0, mem_err sticky until rst.
- enable=0 during MEM for 5 cycles → counter frozen, no pulses, and on re-enable the remaining wait continues. Check retired_cnt preload wrap 0xFFFF_FFFF → 0.
